// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and constants for the packet-aware FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int EOP_BIT         = 8;
  localparam int PAYLOAD_WIDTH   = 8;
  localparam int DEFAULT_NUM_REQ = 4;
  localparam int STATS_WIDTH     = 16;

  typedef logic [STATS_WIDTH-1:0] stats_cnt_t;

endpackage

// File: rtl/fifo_write_arbiter_rr_priority_select.sv
// Combinational round-robin pick: first active request searching circularly from last_idx+1.
module rr_priority_select
  import fifo_arb_pkg::*;
#(
  parameter int NumReq   = DEFAULT_NUM_REQ,
  parameter int IdxWidth = 2
) (
  input  logic [NumReq-1:0]   req,
  input  logic [IdxWidth-1:0] last_idx,
  output logic [IdxWidth-1:0] next_idx,
  output logic                any_req
);

  logic [IdxWidth-1:0] cand;
  logic                found;

  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NumReq; k++) begin
      cand = IdxWidth'((int'(last_idx) + k) % NumReq);
      if (!found && req[cand]) begin
        next_idx = cand;
        found    = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-aware round-robin arbiter sharing one FWFT FIFO write port among NumReq producers.
// Define FIFO_WRITE_ARBITER_STATS_EN to add per-requester packet counters on pkt_count.
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin (1 cycle, nothing accepted)
// LOCK  | grant_idx owns the write port until its EOP word is accepted
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NumReq   = DEFAULT_NUM_REQ,
  parameter int Width    = 9,
  parameter int IdxWidth = 2
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic [NumReq-1:0]       req_valid,
  input  logic [NumReq*Width-1:0] req_data,
  output logic [NumReq-1:0]       req_ready,
  output logic [Width-1:0]        fifo_din,
  output logic                    fifo_wr_en,
  input  logic                    fifo_full,
  input  logic                    fifo_prog_full,
  output logic [IdxWidth-1:0]     grant_idx,
  output logic                    busy,
  output logic                    eop_err
`ifdef FIFO_WRITE_ARBITER_STATS_EN
  ,
  output logic [NumReq*STATS_WIDTH-1:0] pkt_count
`endif
);

  arb_state_e          state;
  logic [IdxWidth-1:0] last_grant;
  logic [IdxWidth-1:0] next_idx;
  logic                any_req;
  logic                sel_valid;
  logic                space_ok;
  logic                xfer;
  logic                xfer_eop;
  logic [Width-1:0]    words [NumReq];
  logic [Width-1:0]    sel_word;

  for (genvar i = 0; i < NumReq; i++) begin : g_unpack
    assign words[i] = req_data[i*Width +: Width];
  end

  rr_priority_select #(
    .NumReq   (NumReq),
    .IdxWidth (IdxWidth)
  ) u_rr_priority_select (
    .req      (req_valid),
    .last_idx (last_grant),
    .next_idx (next_idx),
    .any_req  (any_req)
  );

  // Ready is combinational on the FIFO flags so at most one word is in flight past prog_full.
  assign sel_valid = req_valid[grant_idx];
  assign sel_word  = words[grant_idx];
  assign space_ok  = ~fifo_prog_full & ~fifo_full;
  assign xfer      = (state == LOCK) & sel_valid & space_ok;
  assign xfer_eop  = xfer & sel_word[EOP_BIT];

  always_comb begin
    req_ready = '0;
    if (state == LOCK) req_ready[grant_idx] = space_ok;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state      <= IDLE;
      last_grant <= IdxWidth'(NumReq - 1);
      grant_idx  <= '0;
      busy       <= 1'b0;
      fifo_din   <= '0;
      fifo_wr_en <= 1'b0;
      eop_err    <= 1'b0;
    end else begin
      fifo_wr_en <= xfer;
      eop_err    <= fifo_wr_en & fifo_full;
      if (xfer) fifo_din <= sel_word;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_idx <= next_idx;
            busy      <= 1'b1;
            state     <= LOCK;
          end
        end
        LOCK: begin
          if (xfer_eop) begin
            last_grant <= grant_idx;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_WRITE_ARBITER_STATS_EN
  stats_cnt_t pkt_cnt [NumReq];

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < NumReq; i++) pkt_cnt[i] <= '0;
    end else if (xfer_eop) begin
      pkt_cnt[grant_idx] <= pkt_cnt[grant_idx] + 1'b1;
    end
  end

  for (genvar i = 0; i < NumReq; i++) begin : g_stats
    assign pkt_count[i*STATS_WIDTH +: STATS_WIDTH] = pkt_cnt[i];
  end
`endif

endmodule
